drive_sequencer: RTL and testbench
==================================

Name: drive_sequencer

Overview:
Top-level motion controller for the line-following car. It sits between the tracker sensor decoder, the ultrasonic obstacle detector, the motor PWM block and the H-bridge direction pins. It sequences the car through the idle, run, obstacle-hold, lost-line search and halted phases. It replaces the free-running combinational direction mux with a registered FSM that adds an obstacle clear-time hysteresis and a timed search for a lost line.

Parameters:
CLEAR_CYCLES, 5_000_000, consecutive obstacle-free cycles required before resuming (50 ms at 100 MHz)
LOST_CYCLES, 10_000_000, consecutive STOP reports from the tracker before entering search
SEARCH_CYCLES, 100_000_000, maximum search duration before halting
CNT_W, 27, counter width; must hold the largest of the three cycle parameters

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse (already debounced and one-pulsed) that arms the car
track_mode  in  3  tracker decision: 000 turn_left, 001 turn_right, 010 straight, 011 stop, 100 sharp_left, 101 sharp_right
obstacle  in  1  level from the sonic block; 1 = object within stop distance
mode  out  3  registered mode to the motor PWM block; same encoding as track_mode
left  out  2  registered left H-bridge direction bits
right  out  2  registered right H-bridge direction bits
fsm_state  out  3  current state, for LEDs and debug

Behaviour:
- States: IDLE=0, RUN=1, BLOCKED=2, SEARCH=3, HALTED=4. Values 5-7 are unreachable; if entered, recover to IDLE next cycle.
- Reset values: fsm_state=IDLE, mode=011, {left,right}=0000, all counters=0, last_turn=LEFT.
- All outputs are registered. Latency from input to output is 1 cycle; the output reflects the state and inputs sampled at the previous edge.
- Direction map applied to the commanded mode: turn_left 0010, turn_right 1000, straight 1010, sharp_left 0110, sharp_right 1001, stop 0000. Undefined modes (110, 111) are treated as stop.
- IDLE: commands stop. start=1 -> RUN.
- RUN: mode=track_mode.
  - last_turn <= LEFT on 000/100 and RIGHT on 001/101; otherwise it holds.
  - Priority 1: obstacle=1 -> BLOCKED, with mode=stop in the same output cycle.
  - Priority 2: track_mode is stop or undefined -> lost_cnt++. When lost_cnt reaches LOST_CYCLES-1 -> SEARCH. Any valid moving mode clears lost_cnt.
- BLOCKED: commands stop.
  - obstacle=0 increments clear_cnt; obstacle=1 clears it.
  - When clear_cnt reaches CLEAR_CYCLES-1 -> RUN, and clear_cnt and lost_cnt are cleared.
- SEARCH: mode=sharp_left if last_turn=LEFT, else sharp_right. search_cnt++.
  - Priority 1: obstacle=1 -> BLOCKED, with search_cnt cleared.
  - Priority 2: track_mode valid and not stop -> RUN, with lost_cnt cleared.
  - Priority 3: search_cnt reaches SEARCH_CYCLES-1 -> HALTED.
- HALTED: commands stop. start=1 -> RUN with all counters cleared.
- start is ignored in RUN, BLOCKED and SEARCH.
- Counters saturate at their terminal value and never wrap. A counter is cleared on every state entry except where noted above.
- rst asserted in any state, mid-count included, forces the reset values at the next edge and overrides start.
- With CLEAR_CYCLES=1, the first obstacle-free cycle resumes RUN. The same rule applies to LOST_CYCLES=1 and SEARCH_CYCLES=1.

Decomposition:
- Package drive_pkg holds:
  - the mode encodings (TURN_LEFT..SHARP_RIGHT);
  - the FSM state encodings;
  - a function mode_to_dir(mode) returning the 4-bit {left,right} value;
  - a constant LEFT/RIGHT encoding for last_turn.
- One sub-module, run_timer: a CNT_W counter with clear and enable inputs, a terminal-value parameter, saturation, and a registered done flag. It is instantiated three times (clear, lost, search).

Test Plan:
(Bench overrides CLEAR_CYCLES=4, LOST_CYCLES=3, SEARCH_CYCLES=5.)
- Reset then idle: rst=1 for 2 cycles, release, track_mode=010, no start -> fsm_state=0, mode=011, {left,right}=0000 indefinitely.
- Start and follow: start pulse, then track_mode=010/000/101 on consecutive cycles -> fsm_state=1; {left,right}=1010, 0010, 1001, each one cycle after its input.
- Obstacle hysteresis: in RUN, obstacle=1 for 1 cycle, then 0 for 2, 1 for 1, then 0 -> BLOCKED entered next cycle with outputs 0000; RUN re-entered exactly 4 clear cycles after the last obstacle=1.
- Lost line and recover: last moving mode=001, then track_mode=011 for 3 cycles -> SEARCH with mode=101 and {left,right}=1001; track_mode=010 in cycle 2 of search -> RUN, output 1010.
- Search timeout: enter SEARCH with last_turn=LEFT, track_mode held at 011 -> mode=100 for 5 cycles, then HALTED with output 0000; start pulse -> RUN.
- Reset mid-operation: rst=1 while BLOCKED with clear_cnt=2, with start=1 on the same cycle -> next edge gives IDLE, mode=011, all counters 0.

Source files
------------

// File: rtl/drive_pkg.sv
// drive_pkg: shared encodings for the line-follower motion controller.
//   - tracker/motor mode encodings (TURN_LEFT..SHARP_RIGHT)
//   - sequencer FSM state encodings
//   - last_turn memory encoding
//   - mode_to_dir(): mode -> {left[1:0], right[1:0]} H-bridge bits
//   - is_moving(): true for the five valid non-stop modes
package drive_pkg;

    localparam logic [2:0] TURN_LEFT   = 3'b000;
    localparam logic [2:0] TURN_RIGHT  = 3'b001;
    localparam logic [2:0] STRAIGHT    = 3'b010;
    localparam logic [2:0] STOP        = 3'b011;
    localparam logic [2:0] SHARP_LEFT  = 3'b100;
    localparam logic [2:0] SHARP_RIGHT = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_BLOCKED = 3'd2,
        ST_SEARCH  = 3'd3,
        ST_HALTED  = 3'd4
    } state_e;

    typedef enum logic {
        TURN_LAST_LEFT  = 1'b0,
        TURN_LAST_RIGHT = 1'b1
    } last_turn_e;

    // Undefined modes (110, 111) fall through to stop.
    function automatic logic [3:0] mode_to_dir(input logic [2:0] mode);
        logic [3:0] dir;
        case (mode)
            TURN_LEFT:   dir = 4'b0010;
            TURN_RIGHT:  dir = 4'b1000;
            STRAIGHT:    dir = 4'b1010;
            SHARP_LEFT:  dir = 4'b0110;
            SHARP_RIGHT: dir = 4'b1001;
            default:     dir = 4'b0000;
        endcase
        return dir;
    endfunction

    function automatic logic is_moving(input logic [2:0] mode);
        return (mode == TURN_LEFT)  || (mode == TURN_RIGHT) ||
               (mode == STRAIGHT)   || (mode == SHARP_LEFT) ||
               (mode == SHARP_RIGHT);
    endfunction

endpackage

// File: rtl/drive_sequencer_run_timer.sv
// run_timer: saturating up-counter with a registered terminal flag.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   clr_i   clear counter to zero (wins over en_i)
//   en_i    count one step; holds at TERMINAL
//   done_o  registered flag, high while the count equals TERMINAL
module run_timer #(
    parameter int CNT_W    = 27,
    parameter int TERMINAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TERM_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // done tracks cnt_d so it is aligned with cnt_q; a zero terminal is
    // already done straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= (TERM_C == '0);
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == TERM_C);
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: motion sequencer for the line-following car.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | powered up, motors stopped, waiting for start
// RUN     | following the tracker decision
// BLOCKED | obstacle seen, stopped until it stays clear long enough
// SEARCH  | line lost, spinning towards the last turn direction
// HALTED  | search timed out, stopped until start
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   start       one-cycle arm pulse
//   track_mode  tracker decision (drive_pkg mode encoding)
//   obstacle    1 = object within stop distance
//   mode        registered mode to the PWM block
//   left/right  registered H-bridge direction bits
//   fsm_state   current state
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int CLEAR_CYCLES  = 5_000_000,
    parameter int LOST_CYCLES   = 10_000_000,
    parameter int SEARCH_CYCLES = 100_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] track_mode,
    input  logic       obstacle,
    output logic [2:0] mode,
    output logic [1:0] left,
    output logic [1:0] right,
    output logic [2:0] fsm_state
);

    state_e     state_q, state_d;
    last_turn_e last_turn_q, last_turn_d;
    logic [2:0] mode_q, mode_d;
    logic [3:0] dir_q, dir_d;

    logic clear_clr, clear_en, clear_done;
    logic lost_clr,  lost_en,  lost_done;
    logic srch_clr,  srch_en,  srch_done;

    run_timer #(.CNT_W(CNT_W), .TERMINAL(CLEAR_CYCLES - 1)) u_clear_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear_clr),
        .en_i   (clear_en),
        .done_o (clear_done)
    );

    run_timer #(.CNT_W(CNT_W), .TERMINAL(LOST_CYCLES - 1)) u_lost_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lost_clr),
        .en_i   (lost_en),
        .done_o (lost_done)
    );

    run_timer #(.CNT_W(CNT_W), .TERMINAL(SEARCH_CYCLES - 1)) u_search_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (srch_clr),
        .en_i   (srch_en),
        .done_o (srch_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_turn_q <= TURN_LAST_LEFT;
            mode_q      <= STOP;
            dir_q       <= 4'b0000;
        end else begin
            state_q     <= state_d;
            last_turn_q <= last_turn_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
        end
    end

    // Timers count only while their own state is holding; every other
    // path clears them, which also covers clearing on state entry.
    // A transition fires on the counting cycle where the timer already
    // sits at its terminal value, i.e. the N-th qualifying cycle.
    always_comb begin
        state_d     = state_q;
        last_turn_d = last_turn_q;
        clear_clr   = 1'b1;
        clear_en    = 1'b0;
        lost_clr    = 1'b1;
        lost_en     = 1'b0;
        srch_clr    = 1'b1;
        srch_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if ((track_mode == TURN_LEFT) || (track_mode == SHARP_LEFT)) begin
                    last_turn_d = TURN_LAST_LEFT;
                end else if ((track_mode == TURN_RIGHT) || (track_mode == SHARP_RIGHT)) begin
                    last_turn_d = TURN_LAST_RIGHT;
                end
                if (obstacle) begin
                    state_d = ST_BLOCKED;
                end else if (!is_moving(track_mode)) begin
                    if (lost_done) begin
                        state_d = ST_SEARCH;
                    end else begin
                        lost_clr = 1'b0;
                        lost_en  = 1'b1;
                    end
                end
            end
            ST_BLOCKED: begin
                if (!obstacle) begin
                    if (clear_done) begin
                        state_d = ST_RUN;
                    end else begin
                        clear_clr = 1'b0;
                        clear_en  = 1'b1;
                    end
                end
            end
            ST_SEARCH: begin
                if (obstacle) begin
                    state_d = ST_BLOCKED;
                end else if (is_moving(track_mode)) begin
                    state_d = ST_RUN;
                end else if (srch_done) begin
                    state_d = ST_HALTED;
                end else begin
                    srch_clr = 1'b0;
                    srch_en  = 1'b1;
                end
            end
            ST_HALTED: begin
                if (start) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs follow the state being entered so that, for example, the
    // cycle that enters BLOCKED already commands stop.
    always_comb begin
        mode_d = STOP;
        case (state_d)
            ST_RUN:    mode_d = track_mode;
            ST_SEARCH: mode_d = (last_turn_d == TURN_LAST_LEFT) ? SHARP_LEFT : SHARP_RIGHT;
            default:   mode_d = STOP;
        endcase
        dir_d = mode_to_dir(mode_d);
    end

    assign mode      = mode_q;
    assign left      = dir_q[3:2];
    assign right     = dir_q[1:0];
    assign fsm_state = state_q;

endmodule

// File: tb/tb_drive_sequencer.sv
module tb_drive_sequencer;

    localparam int CLEAR_N  = 4;
    localparam int LOST_N   = 3;
    localparam int SEARCH_N = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] track_mode = 3'b011;
    logic       obstacle = 1'b0;
    logic [2:0] mode;
    logic [1:0] left;
    logic [1:0] right;
    logic [2:0] fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase name as an integer 0..4, counts of
    // consecutive qualifying cycles compared against the full cycle counts.
    int         m_phase;
    int         m_stop_run;
    int         m_clear_run;
    int         m_search_age;
    bit         m_went_left;
    logic [2:0] m_mode;
    logic [3:0] m_dir;

    always #5 clk = ~clk;

    drive_sequencer #(
        .CLEAR_CYCLES  (CLEAR_N),
        .LOST_CYCLES   (LOST_N),
        .SEARCH_CYCLES (SEARCH_N),
        .CNT_W         (27)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .track_mode (track_mode),
        .obstacle   (obstacle),
        .mode       (mode),
        .left       (left),
        .right      (right),
        .fsm_state  (fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_dir(input logic [2:0] md);
        case (md)
            3'b000:  return 4'b0010;
            3'b001:  return 4'b1000;
            3'b010:  return 4'b1010;
            3'b100:  return 4'b0110;
            3'b101:  return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit ref_moving(input logic [2:0] md);
        return (md <= 3'b010) || (md == 3'b100) || (md == 3'b101);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic [2:0] tm, input logic o);
        int nxt;
        if (r) begin
            m_phase = 0; m_stop_run = 0; m_clear_run = 0; m_search_age = 0;
            m_went_left = 1'b1; m_mode = 3'b011; m_dir = 4'b0000;
            return;
        end
        nxt = m_phase;
        case (m_phase)
            0: if (s) nxt = 1;
            1: begin
                if (tm == 3'b000 || tm == 3'b100) m_went_left = 1'b1;
                else if (tm == 3'b001 || tm == 3'b101) m_went_left = 1'b0;
                if (o) nxt = 2;
                else if (ref_moving(tm)) m_stop_run = 0;
                else begin
                    m_stop_run++;
                    if (m_stop_run >= LOST_N) nxt = 3;
                end
            end
            2: begin
                if (o) m_clear_run = 0;
                else begin
                    m_clear_run++;
                    if (m_clear_run >= CLEAR_N) nxt = 1;
                end
            end
            3: begin
                m_search_age++;
                if (o) nxt = 2;
                else if (ref_moving(tm)) nxt = 1;
                else if (m_search_age >= SEARCH_N) nxt = 4;
            end
            4: if (s) nxt = 1;
            default: nxt = 0;
        endcase
        if (nxt != m_phase) begin
            m_stop_run = 0; m_clear_run = 0; m_search_age = 0;
        end
        m_phase = nxt;
        if (nxt == 1) m_mode = tm;
        else if (nxt == 3) m_mode = m_went_left ? 3'b100 : 3'b101;
        else m_mode = 3'b011;
        m_dir = ref_dir(m_mode);
    endtask

    task automatic cycle(input logic r, input logic s, input logic [2:0] tm, input logic o);
        rst = r; start = s; track_mode = tm; obstacle = o;
        model_step(r, s, tm, o);
        @(posedge clk);
        #1;
        chk("fsm_state", 32'(fsm_state), 32'(m_phase));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("dir", 32'({left, right}), 32'(m_dir));
    endtask

    initial begin
        logic r, s, o;
        logic [2:0] tm;

        // reset then idle
        cycle(1, 0, 3'b010, 0);
        cycle(1, 0, 3'b010, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 3'b010, 0);
        chk("idle_state", 32'(fsm_state), 32'd0);
        chk("idle_mode", 32'(mode), 32'd3);

        // start and follow
        cycle(0, 1, 3'b010, 0);
        cycle(0, 0, 3'b010, 0);
        chk("follow_straight", 32'({left, right}), 32'b1010);
        cycle(0, 0, 3'b000, 0);
        chk("follow_left", 32'({left, right}), 32'b0010);
        cycle(0, 0, 3'b101, 0);
        chk("follow_sharp_right", 32'({left, right}), 32'b1001);
        chk("follow_state", 32'(fsm_state), 32'd1);

        // obstacle hysteresis
        cycle(0, 0, 3'b010, 1);
        chk("blocked_entry", 32'(fsm_state), 32'd2);
        chk("blocked_dir", 32'({left, right}), 32'd0);
        cycle(0, 0, 3'b010, 0);
        cycle(0, 0, 3'b010, 0);
        cycle(0, 0, 3'b010, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 3'b010, 0);
        chk("still_blocked", 32'(fsm_state), 32'd2);
        cycle(0, 0, 3'b010, 0);
        chk("resume_run", 32'(fsm_state), 32'd1);

        // lost line and recover
        cycle(0, 0, 3'b001, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 3'b011, 0);
        chk("search_entry", 32'(fsm_state), 32'd3);
        chk("search_mode", 32'(mode), 32'b101);
        chk("search_dir", 32'({left, right}), 32'b1001);
        cycle(0, 0, 3'b011, 0);
        cycle(0, 0, 3'b010, 0);
        chk("recover_state", 32'(fsm_state), 32'd1);
        chk("recover_dir", 32'({left, right}), 32'b1010);

        // search timeout
        cycle(0, 0, 3'b000, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 3'b011, 0);
        chk("timeout_first", 32'(mode), 32'b100);
        for (int i = 0; i < 4; i++) cycle(0, 0, 3'b011, 0);
        chk("timeout_last", 32'(mode), 32'b100);
        cycle(0, 0, 3'b011, 0);
        chk("halted_state", 32'(fsm_state), 32'd4);
        chk("halted_dir", 32'({left, right}), 32'd0);
        cycle(0, 1, 3'b010, 0);
        chk("halted_restart", 32'(fsm_state), 32'd1);

        // reset mid-operation, overriding start
        cycle(0, 0, 3'b010, 1);
        cycle(0, 0, 3'b010, 0);
        cycle(0, 0, 3'b010, 0);
        cycle(1, 1, 3'b010, 0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_mode", 32'(mode), 32'd3);
        // fresh counters: a full CLEAR_N clear run is needed again
        cycle(0, 1, 3'b010, 0);
        cycle(0, 0, 3'b010, 1);
        for (int i = 0; i < CLEAR_N - 1; i++) cycle(0, 0, 3'b010, 0);
        chk("rst_clear_cnt", 32'(fsm_state), 32'd2);
        cycle(0, 0, 3'b010, 0);
        chk("rst_clear_done", 32'(fsm_state), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            s  = ($urandom_range(0, 11) == 0);
            tm = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'($urandom_range(0, 7));
            o  = ($urandom_range(0, 9) < 2);
            cycle(r, s, tm, o);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
